sync_fifo_burst_reader: RTL

Read-side engine for the team's synchronous counting FIFO (`rd_en`/`data_out`/`empty`/`fifo_cnt` interface). It waits until the FIFO holds a full burst, or until a partial burst has aged out. It then drains exactly that many words and presents them on a valid/ready stream with a last-beat marker. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, so downstream backpressure never drops or duplicates a word.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_burst_reader_if.sv | 25 ++
 rtl/sync_fifo_burst_reader_skid_buf2.sv | 48 ++++
 rtl/sync_fifo_burst_reader.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous counting FIFO and its burst reader.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } burst_rd_state_t;

  // Occupancy counter width: must be able to represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_burst_reader_if.sv
// FIFO read port plus valid/ready output stream of the burst reader.
// master = reader side, slave = FIFO / downstream consumer side.
interface sync_fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 5
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output fifo_rd_en, m_data, m_valid, m_last,
    input  fifo_data, fifo_empty, fifo_cnt, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_data, m_valid, m_last,
    output fifo_data, fifo_empty, fifo_cnt, m_ready
  );
endinterface

// File: rtl/sync_fifo_burst_reader_skid_buf2.sv
// Two-entry in-order skid buffer; entry 0 is always the head.
module skid_buf2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [1:0]            o_occ
);
  logic [1:0][DATA_WIDTH-1:0] r_mem;
  logic [1:0]                 r_occ;

  assign o_data  = r_mem[0];
  assign o_valid = (r_occ != 2'd0);
  assign o_occ   = r_occ;

  // Shift-on-pop storage; a simultaneous push lands behind whatever remains.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ <= 2'd0;
      r_mem <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          r_mem[r_occ[0]] <= i_data;
          r_occ           <= r_occ + 2'd1;
        end
        2'b01: begin
          r_mem[0] <= r_mem[1];
          r_occ    <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_mem[0] <= r_mem[1];
            r_mem[1] <= i_data;
          end else begin
            r_mem[0] <= i_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sync_fifo_burst_reader.sv
// Burst read engine for the synchronous counting FIFO.
// Optional partial-burst flush on idle timeout: SYNC_FIFO_BURST_READER_TIMEOUT_EN.
module sync_fifo_burst_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  sync_fifo_burst_reader_if.master bus,
  output logic                     busy
);
  localparam int CNT_W = cnt_w(DATA_DEPTH);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  if (TIMEOUT < 1 || BURST_LEN < 1 || BURST_LEN > DATA_DEPTH) begin : g_bad_cfg
    $error("sync_fifo_burst_reader: illegal BURST_LEN/TIMEOUT");
  end

  burst_rd_state_t       r_state;
  logic [CNT_W-1:0]      r_reads_left;
  logic [CNT_W-1:0]      r_beats_left;
  logic                  r_inflight;
  logic                  r_busy;

  logic [1:0]            w_occ;
  logic                  w_skid_valid;
  logic [DATA_WIDTH-1:0] w_skid_data;
  logic                  w_pop;
  logic                  w_rd_en;
  logic                  w_full;
  logic                  w_trig;
  logic [CNT_W-1:0]      w_trig_len;

  // A read is only launched when the skid is guaranteed a slot for its data.
  assign w_rd_en = (r_state == BURST) && !bus.fifo_empty && (r_reads_left != '0) &&
                   ((w_occ + 2'(r_inflight)) < 2'd2);
  assign w_pop   = w_skid_valid && bus.m_ready;
  assign w_full  = (bus.fifo_cnt >= BURST_CNT);

`ifdef SYNC_FIFO_BURST_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_timer;
  logic          w_timeout;

  assign w_timeout  = (r_state == IDLE) && !bus.fifo_empty && (r_timer == TW'(TIMEOUT));
  assign w_trig     = (r_state == IDLE) && (w_full || w_timeout);
  assign w_trig_len = w_full ? BURST_CNT : bus.fifo_cnt;

  // Age of the oldest unserved data while idling; restarts whenever the FIFO empties.
  always_ff @(posedge clk) begin
    if (rst)                          r_timer <= '0;
    else if (bus.fifo_empty || w_trig) r_timer <= '0;
    else if (r_state == IDLE)          r_timer <= r_timer + TW'(1);
  end
`else
  assign w_trig     = (r_state == IDLE) && w_full;
  assign w_trig_len = BURST_CNT;
`endif

  // Burst sequencing: latch length, count reads and beats, retire on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_reads_left <= '0;
      r_beats_left <= '0;
      r_inflight   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) r_reads_left <= r_reads_left - ONE;
      if (w_pop)   r_beats_left <= r_beats_left - ONE;
      case (r_state)
        IDLE: if (w_trig) begin
          r_state      <= BURST;
          r_busy       <= 1'b1;
          r_reads_left <= w_trig_len;
          r_beats_left <= w_trig_len;
        end
        BURST: begin
          if (w_pop && r_beats_left == ONE) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_rd_en && r_reads_left == ONE) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: if (w_pop && r_beats_left == ONE) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_inflight),
    .i_data  (bus.fifo_data),
    .i_pop   (w_pop),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid),
    .o_occ   (w_occ)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_data     = w_skid_data;
  assign bus.m_valid    = w_skid_valid;
  assign bus.m_last     = w_skid_valid && (r_beats_left == ONE);
  assign busy           = r_busy;
endmodule
